// File: rtl/uid_ctrl_multi.sv
// uid_ctrl_multi: multi-button UID LED / BMC reset controller.
//   - NUM_BTN active-low buttons, each synchronised and debounced on i_20mSEC,
//     merged into one press that is timed in i_20mSEC ticks.
//   - A press is classified as short (toggle on release), long (sticky flag)
//     or reset-hold (timed active-low BMC reset pulse).
//   - UID LED is driven by an OFF/ON/BLINK machine controlled by BMC
//     commands, short presses and the BMC virtual button.
// Optional feature macro: UID_BTN_LOCK_EN adds i_btn_lock, which masks the
// physical buttons while high.
module uid_ctrl_multi #(
  parameter int NUM_BTN      = 2,
  parameter int FILT_STAGES  = 3,
  parameter int TICKS_PER_S  = 50,
  parameter int LONG_PRESS_S = 6,
  parameter int RST_PRESS_S  = 9,
  parameter int RST_PULSE_MS = 100
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_1mSEC,
  input  logic               i_20mSEC,
  input  logic [NUM_BTN-1:0] i_btn_n,
  input  logic               i_bmc_btn_n,
`ifdef UID_BTN_LOCK_EN
  input  logic               i_btn_lock,
`endif
  input  logic               i_uid_valid,
  input  logic [7:0]         i_uid_cmd,
  input  logic               i_clr_short,
  input  logic               i_clr_long,
  output logic               o_uid_led_n,
  output logic               o_bmc_rst_n,
  output logic               o_short_pulse,
  output logic               o_short_flag,
  output logic               o_long_flag,
  output logic [7:0]         o_uid_state
);

  localparam int CNT_MAX = RST_PRESS_S * TICKS_PER_S;
  localparam int LONG_TH = LONG_PRESS_S * TICKS_PER_S;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FILT_STAGES + 1);
  localparam int PW      = $clog2(RST_PULSE_MS + 1);

  localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_PRE_C = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] LONG_C    = CW'(LONG_TH);
  localparam logic [CW-1:0] LONG_PRE  = CW'(LONG_TH - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_STAGES - 1);
  localparam logic [PW-1:0] PULSE_END = PW'(RST_PULSE_MS - 1);

  typedef enum logic [1:0] {ST_OFF, ST_ON, ST_BLINK} led_state_e;

  // Synchroniser, debounce and press-timing state
  logic [NUM_BTN-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [NUM_BTN-1:0] filt_q, filt_d;
  logic [FW-1:0]      fcnt_q [NUM_BTN];
  logic [FW-1:0]      fcnt_d [NUM_BTN];
  logic               bmc_s1_q, bmc_s1_d, bmc_s2_q, bmc_s2_d, bmc_s3_q, bmc_s3_d;
  logic               p1_q, p1_d, p2_q, p2_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rst_act_q, rst_act_d;
  logic [PW-1:0]      ms_cnt_q, ms_cnt_d;
  logic               bmc_rst_n_q, bmc_rst_n_d;
  logic               short_pulse_q, short_pulse_d;
  logic               short_flag_q, short_flag_d;
  logic               long_flag_q, long_flag_d;

  // LED machine state
  led_state_e         state_q;
  logic [7:0]         rate_q;
  logic [8:0]         phase_q;
  logic [8:0]         half_m1;
  logic               led_n_q;
  logic [7:0]         uid_state_q;

  logic btn_lock, press, inc, release_evt, short_evt, long_set, fire;
  logic bmc_fall, toggle, cmd_ok;

`ifdef UID_BTN_LOCK_EN
  assign btn_lock = i_btn_lock;
`else
  assign btn_lock = 1'b0;
`endif

  // Next-state logic for debounce, press counter, flags and BMC reset pulse
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no latch can be inferred.
    btn_s1_d = i_btn_n;
    btn_s2_d = btn_s1_q;
    bmc_s1_d = i_bmc_btn_n;
    bmc_s2_d = bmc_s1_q;
    bmc_s3_d = bmc_s2_q;
    filt_d   = filt_q;
    fcnt_d   = fcnt_q;

    if (i_20mSEC) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_s2_q[i] == filt_q[i]) begin
          fcnt_d[i] = '0;
        end else if (fcnt_q[i] == FILT_LAST) begin
          filt_d[i] = btn_s2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + FW'(1);
        end
      end
    end

    press       = ~(&filt_q) & ~btn_lock;
    p1_d        = press;
    p2_d        = p1_q;
    inc         = p2_q & i_20mSEC & (cnt_q != CNT_MAX_C);
    release_evt = p2_q & ~p1_q;
    short_evt   = release_evt & (cnt_q < LONG_C) & ~btn_lock;
    long_set    = inc & (cnt_q == LONG_PRE);
    fire        = inc & (cnt_q == CNT_PRE_C);

    // Counter is frozen during a reset pulse so a held button cannot re-fire.
    if (btn_lock)                  cnt_d = '0;
    else if (inc)                  cnt_d = cnt_q + CW'(1);
    else if (!p2_q && !rst_act_q)  cnt_d = '0;
    else                           cnt_d = cnt_q;

    rst_act_d = rst_act_q;
    ms_cnt_d  = ms_cnt_q;
    if (rst_act_q) begin
      if (i_1mSEC) begin
        if (ms_cnt_q == PULSE_END) begin
          rst_act_d = 1'b0;
          ms_cnt_d  = '0;
        end else begin
          ms_cnt_d = ms_cnt_q + PW'(1);
        end
      end
    end else if (fire) begin
      rst_act_d = 1'b1;
      ms_cnt_d  = '0;
    end
    bmc_rst_n_d = ~rst_act_d;

    // Clear beats a simultaneous set.
    short_pulse_d = short_evt;
    short_flag_d  = i_clr_short ? 1'b0 : (short_evt ? 1'b1 : short_flag_q);
    long_flag_d   = i_clr_long  ? 1'b0 : (long_set  ? 1'b1 : long_flag_q);

    bmc_fall = bmc_s3_q & ~bmc_s2_q;
    toggle   = short_evt | bmc_fall;
  end

  // Register the datapath state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the raw buttons are asynchronous, so they pass two flops before use.
      btn_s1_q      <= '1;
      btn_s2_q      <= '1;
      filt_q        <= '1;
      // NOTE: fcnt is a small array of flops, not a RAM, so resetting it is cheap and safe.
      for (int i = 0; i < NUM_BTN; i++) fcnt_q[i] <= '0;
      bmc_s1_q      <= 1'b1;
      bmc_s2_q      <= 1'b1;
      bmc_s3_q      <= 1'b1;
      p1_q          <= 1'b0;
      p2_q          <= 1'b0;
      cnt_q         <= '0;
      rst_act_q     <= 1'b0;
      ms_cnt_q      <= '0;
      bmc_rst_n_q   <= 1'b1;
      short_pulse_q <= 1'b0;
      short_flag_q  <= 1'b0;
      long_flag_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      btn_s1_q      <= btn_s1_d;
      btn_s2_q      <= btn_s2_d;
      filt_q        <= filt_d;
      fcnt_q        <= fcnt_d;
      bmc_s1_q      <= bmc_s1_d;
      bmc_s2_q      <= bmc_s2_d;
      bmc_s3_q      <= bmc_s3_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      cnt_q         <= cnt_d;
      rst_act_q     <= rst_act_d;
      ms_cnt_q      <= ms_cnt_d;
      bmc_rst_n_q   <= bmc_rst_n_d;
      short_pulse_q <= short_pulse_d;
      short_flag_q  <= short_flag_d;
      long_flag_q   <= long_flag_d;
    end
  end

  // Recognised command codes and blink half-period (minus one) in ms
  always_comb begin
    cmd_ok = i_uid_valid & ((i_uid_cmd == 8'h00) | (i_uid_cmd == 8'hFF) |
                            (i_uid_cmd == 8'h01) | (i_uid_cmd == 8'h02) |
                            (i_uid_cmd == 8'h04));
    case (rate_q)
      8'h02:   half_m1 = 9'd249;
      8'h04:   half_m1 = 9'd124;
      default: half_m1 = 9'd499;
    endcase
  end

  // LED machine: command beats toggle; any blink command restarts the phase lit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_OFF;
      rate_q      <= 8'h01;
      phase_q     <= '0;
      led_n_q     <= 1'b1;
      uid_state_q <= 8'h00;
    end else if (cmd_ok) begin
      case (i_uid_cmd)
        8'h00: begin
          state_q     <= ST_OFF;
          led_n_q     <= 1'b1;
          uid_state_q <= 8'h00;
        end
        8'hFF: begin
          state_q     <= ST_ON;
          led_n_q     <= 1'b0;
          uid_state_q <= 8'hFF;
        end
        default: begin
          state_q     <= ST_BLINK;
          rate_q      <= i_uid_cmd;
          phase_q     <= '0;
          led_n_q     <= 1'b0;
          uid_state_q <= i_uid_cmd;
        end
      endcase
    end else if (toggle) begin
      if (state_q == ST_ON) begin
        state_q     <= ST_OFF;
        led_n_q     <= 1'b1;
        uid_state_q <= 8'h00;
      end else begin
        state_q     <= ST_ON;
        led_n_q     <= 1'b0;
        uid_state_q <= 8'hFF;
      end
    end else if (state_q == ST_BLINK && i_1mSEC) begin
      if (phase_q == half_m1) begin
        phase_q <= '0;
        led_n_q <= ~led_n_q;
      end else begin
        phase_q <= phase_q + 9'd1;
      end
    end
  end

  assign o_uid_led_n   = led_n_q;
  assign o_bmc_rst_n   = bmc_rst_n_q;
  assign o_short_pulse = short_pulse_q;
  assign o_short_flag  = short_flag_q;
  assign o_long_flag   = long_flag_q;
  assign o_uid_state   = uid_state_q;

endmodule

// File: tb/tb_uid_ctrl_multi.sv
// Directed testbench for uid_ctrl_multi (default parameters).
// Time base: i_1mSEC every 2 clocks, i_20mSEC on every 20th ms strobe.
module tb_uid_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_1mSEC, i_20mSEC;
  logic [1:0] i_btn_n;
  logic       i_bmc_btn_n;
  logic       i_uid_valid;
  logic [7:0] i_uid_cmd;
  logic       i_clr_short, i_clr_long;
`ifdef UID_BTN_LOCK_EN
  logic       i_btn_lock;
`endif
  logic       o_uid_led_n, o_bmc_rst_n, o_short_pulse, o_short_flag, o_long_flag;
  logic [7:0] o_uid_state;

  int n_checks = 0;
  int n_fail   = 0;
  int short_cnt = 0;

  uid_ctrl_multi dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_1mSEC      (i_1mSEC),
    .i_20mSEC     (i_20mSEC),
    .i_btn_n      (i_btn_n),
    .i_bmc_btn_n  (i_bmc_btn_n),
`ifdef UID_BTN_LOCK_EN
    .i_btn_lock   (i_btn_lock),
`endif
    .i_uid_valid  (i_uid_valid),
    .i_uid_cmd    (i_uid_cmd),
    .i_clr_short  (i_clr_short),
    .i_clr_long   (i_clr_long),
    .o_uid_led_n  (o_uid_led_n),
    .o_bmc_rst_n  (o_bmc_rst_n),
    .o_short_pulse(o_short_pulse),
    .o_short_flag (o_short_flag),
    .o_long_flag  (o_long_flag),
    .o_uid_state  (o_uid_state)
  );

  always #5 clk = ~clk;

  // Strobe generator
  initial begin
    int ph;
    int ms_n;
    ph = 0; ms_n = 0;
    i_1mSEC = 1'b0; i_20mSEC = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ph = 0; ms_n = 0;
        i_1mSEC = 1'b0; i_20mSEC = 1'b0;
      end else begin
        i_1mSEC  = (ph == 1);
        i_20mSEC = (ph == 1) && (ms_n == 19);
        if (ph == 1) ms_n = (ms_n == 19) ? 0 : ms_n + 1;
        ph = ph ^ 1;
      end
    end
  end

  // Count every short pulse cycle seen
  always @(negedge clk) if (rst_n && o_short_pulse) short_cnt++;

  task automatic wait_ms(input int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      if (i_1mSEC) c++;
    end
  endtask

  task automatic set_btn(input logic [1:0] pressed);
    @(posedge clk); #2;
    i_btn_n = ~pressed;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(posedge clk); #2;
    i_uid_valid = 1'b1; i_uid_cmd = c;
    @(posedge clk); #2;
    i_uid_valid = 1'b0;
  endtask

  task automatic pulse_clr(input bit is_long);
    @(posedge clk); #2;
    if (is_long) i_clr_long = 1'b1; else i_clr_short = 1'b1;
    @(posedge clk); #2;
    i_clr_long = 1'b0; i_clr_short = 1'b0;
  endtask

  // Counts ms strobes while the LED holds lvl; carry is the strobe of the cycle where it changed
  task automatic measure_half(input logic lvl, input int start, output int n, output int carry);
    n = start; carry = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (o_uid_led_n !== lvl) begin
        carry = i_1mSEC ? 1 : 0;
        break;
      end
      if (i_1mSEC) n++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (o_uid_led_n !== 1'b1)   begin n_fail++; $display("FAIL reset_led: got %b want 1", o_uid_led_n); end
    n_checks++; if (o_bmc_rst_n !== 1'b1)   begin n_fail++; $display("FAIL reset_bmc_rst: got %b want 1", o_bmc_rst_n); end
    n_checks++; if (o_short_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_short_pulse: got %b want 0", o_short_pulse); end
    n_checks++; if (o_short_flag !== 1'b0)  begin n_fail++; $display("FAIL reset_short_flag: got %b want 0", o_short_flag); end
    n_checks++; if (o_long_flag !== 1'b0)   begin n_fail++; $display("FAIL reset_long_flag: got %b want 0", o_long_flag); end
    n_checks++; if (o_uid_state !== 8'h00)  begin n_fail++; $display("FAIL reset_state: got %h want 00", o_uid_state); end
  endtask

  task automatic test_short_press;
    int  base;
    bit  found;
    base = short_cnt; found = 0;
    set_btn(2'b01);
    wait_ms(1000);
    set_btn(2'b00);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (o_short_pulse) begin found = 1; break; end
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL short_pulse_seen: got %b want 1", found); end
    if (found) begin
      n_checks++; if (o_uid_led_n !== 1'b0) begin n_fail++; $display("FAIL short_led_on: got %b want 0", o_uid_led_n); end
      n_checks++; if (o_uid_state !== 8'hFF) begin n_fail++; $display("FAIL short_state: got %h want FF", o_uid_state); end
    end
    @(negedge clk);
    n_checks++; if (o_short_pulse !== 1'b0) begin n_fail++; $display("FAIL short_pulse_width: got %b want 0", o_short_pulse); end
    n_checks++; if (o_short_flag !== 1'b1) begin n_fail++; $display("FAIL short_flag_set: got %b want 1", o_short_flag); end
    wait_ms(100);
    n_checks++; if (short_cnt - base !== 1) begin n_fail++; $display("FAIL short_count: got %0d want 1", short_cnt - base); end
    pulse_clr(1'b0);
    @(negedge clk);
    n_checks++; if (o_short_flag !== 1'b0) begin n_fail++; $display("FAIL short_flag_clear: got %b want 0", o_short_flag); end
  endtask

  task automatic test_long_press;
    int base;
    int ms;
    bit got;
    base = short_cnt; ms = 0; got = 0;
    set_btn(2'b10);
    while (ms < 6500 && !got) begin
      @(negedge clk);
      if (i_1mSEC) ms++;
      if (o_long_flag) got = 1;
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL long_flag_set: got %b want 1", got); end
    n_checks++; if (ms < 6000 || ms > 6100) begin n_fail++; $display("FAIL long_flag_time: got %0d ms want 6000..6100", ms); end
    wait_ms(7000 - ms);
    set_btn(2'b00);
    wait_ms(300);
    n_checks++; if (short_cnt - base !== 0) begin n_fail++; $display("FAIL long_no_short: got %0d pulses want 0", short_cnt - base); end
    n_checks++; if (o_uid_state !== 8'hFF) begin n_fail++; $display("FAIL long_state: got %h want FF", o_uid_state); end
    n_checks++; if (o_uid_led_n !== 1'b0) begin n_fail++; $display("FAIL long_led: got %b want 0", o_uid_led_n); end
    n_checks++; if (o_long_flag !== 1'b1) begin n_fail++; $display("FAIL long_flag_sticky: got %b want 1", o_long_flag); end
    pulse_clr(1'b1);
    @(negedge clk);
    n_checks++; if (o_long_flag !== 1'b0) begin n_fail++; $display("FAIL long_flag_clear: got %b want 0", o_long_flag); end
  endtask

  // 12 s hold with i_clr_long held high, so the long-flag set cycle collides with clear
  task automatic test_bmc_reset;
    int   base, ms, falls, low_strobes, fall_ms;
    bit   long_seen, released;
    logic prev;
    base = short_cnt; ms = 0; falls = 0; low_strobes = 0; fall_ms = -1;
    long_seen = 0; released = 0; prev = 1'b1;
    @(posedge clk); #2; i_clr_long = 1'b1;
    set_btn(2'b01);
    while (ms < 12300) begin
      @(negedge clk);
      if (i_1mSEC) ms++;
      if (prev === 1'b1 && o_bmc_rst_n === 1'b0) begin falls++; fall_ms = ms; end
      if (o_bmc_rst_n === 1'b0 && i_1mSEC) low_strobes++;
      if (o_long_flag) long_seen = 1;
      prev = o_bmc_rst_n;
      if (ms == 12000 && !released) begin released = 1; i_btn_n = 2'b11; end
    end
    @(posedge clk); #2; i_clr_long = 1'b0;
    n_checks++; if (falls !== 1) begin n_fail++; $display("FAIL rst_pulse_count: got %0d want 1", falls); end
    n_checks++; if (low_strobes !== 100) begin n_fail++; $display("FAIL rst_pulse_width: got %0d strobes want 100", low_strobes); end
    n_checks++; if (fall_ms < 9000 || fall_ms > 9100) begin n_fail++; $display("FAIL rst_pulse_time: got %0d ms want 9000..9100", fall_ms); end
    n_checks++; if (long_seen !== 1'b0) begin n_fail++; $display("FAIL long_clear_wins: got %b want 0", long_seen); end
    n_checks++; if (o_bmc_rst_n !== 1'b1) begin n_fail++; $display("FAIL rst_idle_after: got %b want 1", o_bmc_rst_n); end
    n_checks++; if (short_cnt - base !== 0) begin n_fail++; $display("FAIL rst_no_short: got %0d want 0", short_cnt - base); end
    n_checks++; if (o_uid_state !== 8'hFF) begin n_fail++; $display("FAIL rst_state: got %h want FF", o_uid_state); end
  endtask

  task automatic test_blink;
    int n, carry, carry2;
    send_cmd(8'h02);
    @(negedge clk);
    n_checks++; if (o_uid_state !== 8'h02) begin n_fail++; $display("FAIL blink2_state: got %h want 02", o_uid_state); end
    n_checks++; if (o_uid_led_n !== 1'b0) begin n_fail++; $display("FAIL blink2_start_on: got %b want 0", o_uid_led_n); end
    carry = i_1mSEC ? 1 : 0;
    measure_half(1'b0, carry, n, carry2);
    n_checks++; if (n !== 250) begin n_fail++; $display("FAIL blink2_on_half: got %0d ms want 250", n); end
    measure_half(1'b1, carry2, n, carry);
    n_checks++; if (n !== 250) begin n_fail++; $display("FAIL blink2_off_half: got %0d ms want 250", n); end
    send_cmd(8'h03);
    @(negedge clk);
    n_checks++; if (o_uid_state !== 8'h02) begin n_fail++; $display("FAIL invalid_cmd: got %h want 02", o_uid_state); end
    send_cmd(8'h04);
    @(negedge clk);
    n_checks++; if (o_uid_state !== 8'h04) begin n_fail++; $display("FAIL blink4_state: got %h want 04", o_uid_state); end
    n_checks++; if (o_uid_led_n !== 1'b0) begin n_fail++; $display("FAIL blink4_start_on: got %b want 0", o_uid_led_n); end
    carry = i_1mSEC ? 1 : 0;
    measure_half(1'b0, carry, n, carry2);
    n_checks++; if (n !== 125) begin n_fail++; $display("FAIL blink4_on_half: got %0d ms want 125", n); end
  endtask

  // Command 00 held valid across the cycle the BMC falling edge is detected
  task automatic test_priority;
    bit bad;
    bit got;
    bad = 0; got = 0;
    send_cmd(8'hFF);
    @(negedge clk);
    n_checks++; if (o_uid_state !== 8'hFF) begin n_fail++; $display("FAIL prio_on: got %h want FF", o_uid_state); end
    @(posedge clk); #2;
    i_uid_valid = 1'b1; i_uid_cmd = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      if (k == 1) i_bmc_btn_n = 1'b0;
      @(negedge clk);
      if (o_uid_state !== 8'h00) bad = 1;
    end
    @(posedge clk); #2; i_uid_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL prio_cmd_wins: got toggle=%b want 0", bad); end
    n_checks++; if (o_uid_state !== 8'h00) begin n_fail++; $display("FAIL prio_state: got %h want 00", o_uid_state); end
    n_checks++; if (o_uid_led_n !== 1'b1) begin n_fail++; $display("FAIL prio_led: got %b want 1", o_uid_led_n); end
    @(posedge clk); #2; i_bmc_btn_n = 1'b1;
    repeat (10) @(posedge clk);
    #2; i_bmc_btn_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_uid_state === 8'hFF) begin got = 1; break; end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL bmc_toggle: got %h want FF", o_uid_state); end
    n_checks++; if (o_uid_led_n !== 1'b0) begin n_fail++; $display("FAIL bmc_toggle_led: got %b want 0", o_uid_led_n); end
    @(posedge clk); #2; i_bmc_btn_n = 1'b1;
  endtask

  // Button low for exactly two i_20mSEC samples
  task automatic test_glitch;
    int base;
    int seen;
    base = short_cnt; seen = 0;
    do @(negedge clk); while (i_20mSEC !== 1'b1);
    @(posedge clk); #2; i_btn_n = 2'b10;
    while (seen < 2) begin
      @(negedge clk);
      if (i_20mSEC) seen++;
    end
    @(posedge clk); #2; i_btn_n = 2'b11;
    wait_ms(300);
    n_checks++; if (short_cnt - base !== 0) begin n_fail++; $display("FAIL glitch_no_short: got %0d want 0", short_cnt - base); end
    n_checks++; if (o_uid_state !== 8'hFF) begin n_fail++; $display("FAIL glitch_state: got %h want FF", o_uid_state); end
    n_checks++; if (o_short_flag !== 1'b0) begin n_fail++; $display("FAIL glitch_flag: got %b want 0", o_short_flag); end
  endtask

`ifdef UID_BTN_LOCK_EN
  task automatic test_btn_lock;
    int base, ms;
    bit rst_seen, flag_seen, got;
    base = short_cnt; ms = 0; rst_seen = 0; flag_seen = 0; got = 0;
    @(posedge clk); #2; i_btn_lock = 1'b1;
    set_btn(2'b01);
    while (ms < 10300) begin
      @(negedge clk);
      if (i_1mSEC) ms++;
      if (o_bmc_rst_n === 1'b0) rst_seen = 1;
      if (o_long_flag || o_short_flag) flag_seen = 1;
      if (ms == 10000) i_btn_n = 2'b11;
    end
    n_checks++; if (rst_seen !== 1'b0) begin n_fail++; $display("FAIL lock_no_rst: got %b want 0", rst_seen); end
    n_checks++; if (flag_seen !== 1'b0) begin n_fail++; $display("FAIL lock_no_flags: got %b want 0", flag_seen); end
    n_checks++; if (short_cnt - base !== 0) begin n_fail++; $display("FAIL lock_no_short: got %0d want 0", short_cnt - base); end
    @(posedge clk); #2; i_bmc_btn_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_uid_state === 8'h00) begin got = 1; break; end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL lock_bmc_toggle: got %h want 00", o_uid_state); end
    @(posedge clk); #2; i_bmc_btn_n = 1'b1; i_btn_lock = 1'b0;
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    i_btn_n     = 2'b11;
    i_bmc_btn_n = 1'b1;
    i_uid_valid = 1'b0;
    i_uid_cmd   = 8'h00;
    i_clr_short = 1'b0;
    i_clr_long  = 1'b0;
`ifdef UID_BTN_LOCK_EN
    i_btn_lock  = 1'b0;
`endif
    #33 rst_n = 1'b1;
    test_reset();
    test_short_press();
    test_long_press();
    test_bmc_reset();
    test_blink();
    test_priority();
    test_glitch();
`ifdef UID_BTN_LOCK_EN
    test_btn_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
